// File: rtl/alu_cmd_ctrl.sv
// Byte-serial command front end for a 16-bit ALU: collects operands and a
// function code, strobes the ALU, then returns the 24-bit result MSB first.
// Optional: define ALU_CMD_TIMEOUT_EN to abandon frames stalled for 256 cycles.
module alu_cmd_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [3:0]  alu_fun,
    output logic        alu_en,
    input  logic [16:0] alu_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        rx_drop
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_GET_AH  = 4'd1;
    localparam logic [3:0] S_GET_AL  = 4'd2;
    localparam logic [3:0] S_GET_BH  = 4'd3;
    localparam logic [3:0] S_GET_BL  = 4'd4;
    localparam logic [3:0] S_GET_FUN = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_WAIT    = 4'd7;
    localparam logic [3:0] S_TX2     = 4'd8;
    localparam logic [3:0] S_TX1     = 4'd9;
    localparam logic [3:0] S_TX0     = 4'd10;

    localparam logic [7:0] CMD_FULL  = 8'hCC;
    localparam logic [7:0] CMD_REUSE = 8'hDD;

    logic [3:0]  state_q,    state_d;
    logic [15:0] a_q,        a_d;
    logic [15:0] b_q,        b_d;
    logic [3:0]  fun_q,      fun_d;
    logic [23:0] result_q,   result_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        alu_en_q,   alu_en_d;
    logic        busy_q,     busy_d;
    logic        rx_drop_q,  rx_drop_d;

`ifdef ALU_CMD_TIMEOUT_EN
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic        in_get;
`endif

    always_comb begin
        // NOTE: every variable gets a hold default first so no path can infer a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        fun_d     = fun_q;
        result_d  = result_q;
        rx_drop_d = rx_drop_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_FULL) begin
                        state_d = S_GET_AH;
                    end else if (rx_data == CMD_REUSE) begin
                        state_d = S_GET_FUN;
                    end
                end
            end
            S_GET_AH: begin
                if (rx_valid) begin
                    a_d[15:8] = rx_data;
                    state_d   = S_GET_AL;
                end
            end
            S_GET_AL: begin
                if (rx_valid) begin
                    a_d[7:0] = rx_data;
                    state_d  = S_GET_BH;
                end
            end
            S_GET_BH: begin
                if (rx_valid) begin
                    b_d[15:8] = rx_data;
                    state_d   = S_GET_BL;
                end
            end
            S_GET_BL: begin
                if (rx_valid) begin
                    b_d[7:0] = rx_data;
                    state_d  = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (rx_valid) begin
                    fun_d   = rx_data[3:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                result_d = {7'b0, alu_out};
                state_d  = S_TX2;
            end
            S_TX2: begin
                if (tx_valid_q && tx_ready) state_d = S_TX1;
            end
            S_TX1: begin
                if (tx_valid_q && tx_ready) state_d = S_TX0;
            end
            S_TX0: begin
                if (tx_valid_q && tx_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bytes arriving while a command is in flight are lost; remember that.
        if (rx_valid && (state_q >= S_EXEC) && (state_q <= S_TX0)) begin
            rx_drop_d = 1'b1;
        end

`ifdef ALU_CMD_TIMEOUT_EN
        in_get     = (state_q >= S_GET_AH) && (state_q <= S_GET_FUN);
        idle_cnt_d = 8'd0;
        if (in_get && !rx_valid) begin
            if (idle_cnt_q == 8'hFF) begin
                state_d = S_IDLE;
            end else begin
                idle_cnt_d = idle_cnt_q + 8'd1;
            end
        end
`endif

        // Outputs are registered from the next state so they are glitch-free.
        alu_en_d   = (state_d == S_EXEC);
        busy_d     = (state_d != S_IDLE);
        tx_valid_d = (state_d == S_TX2) || (state_d == S_TX1) || (state_d == S_TX0);
        case (state_d)
            S_TX2:   tx_data_d = result_d[23:16];
            S_TX1:   tx_data_d = result_d[15:8];
            S_TX0:   tx_data_d = result_d[7:0];
            default: tx_data_d = tx_data_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            result_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            alu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            fun_q      <= fun_d;
            result_q   <= result_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            alu_en_q   <= alu_en_d;
            busy_q     <= busy_d;
            rx_drop_q  <= rx_drop_d;
        end
    end

`ifdef ALU_CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign a        = a_q;
    assign b        = b_q;
    assign alu_fun  = fun_q;
    assign alu_en   = alu_en_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: hand-computed frames with a small ALU model
// that either adds a and b or returns a fixed 17-bit constant.
module tb_alu_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [16:0] alu_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        rx_drop;

    logic        alu_mode;
    logic [16:0] alu_const;

    int n_vec;
    int n_miscomp;

    alu_cmd_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .a        (a),
        .b        (b),
        .alu_fun  (alu_fun),
        .alu_en   (alu_en),
        .alu_out  (alu_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .rx_drop  (rx_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial alu_out = '0;
    always @(posedge clk) begin
        if (alu_en) alu_out <= alu_mode ? alu_const : ({1'b0, a} + {1'b0, b});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] d);
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check(tag, 32'(tx_data), 32'(d));
        @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_miscomp = 0;
        rst_n     = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b1;
        alu_mode  = 1'b0;
        alu_const = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_a",        32'(a),        32'h0);
        check("rst_b",        32'(b),        32'h0);
        check("rst_fun",      32'(alu_fun),  32'h0);
        check("rst_alu_en",   32'(alu_en),   32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data",  32'(tx_data),  32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_rx_drop",  32'(rx_drop),  32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        // Full frame, a=0x000F b=0x000A fun=0, ALU adds -> 0x000019
        send_byte(8'hCC);
        send_byte(8'h00);
        send_byte(8'h0F);
        send_byte(8'h00);
        send_byte(8'h0A);
        check("f1_busy",      32'(busy),   32'h1);
        check("f1_no_en_yet", 32'(alu_en), 32'h0);
        send_byte(8'h00);
        check("f1_exec_en",   32'(alu_en),   32'h1);
        check("f1_exec_txv",  32'(tx_valid), 32'h0);
        @(negedge clk);
        check("f1_wait_en",   32'(alu_en),   32'h0);
        check("f1_wait_txv",  32'(tx_valid), 32'h0);
        @(negedge clk);
        expect_tx("f1_tx2", 8'h00);
        expect_tx("f1_tx1", 8'h00);
        expect_tx("f1_tx0", 8'h19);
        check("f1_end_txv",  32'(tx_valid), 32'h0);
        check("f1_end_busy", 32'(busy),     32'h0);
        check("f1_a",        32'(a),        32'h000F);
        check("f1_b",        32'(b),        32'h000A);
        check("f1_fun",      32'(alu_fun),  32'h0);
        check("f1_drop",     32'(rx_drop),  32'h0);

        // Reuse frame with upper bits of the function byte ignored
        alu_mode  = 1'b1;
        alu_const = 17'h1FFF5;
        send_byte(8'hDD);
        send_byte(8'hF6);
        check("f2_exec_en", 32'(alu_en), 32'h1);
        repeat (2) @(negedge clk);
        expect_tx("f2_tx2", 8'h01);
        expect_tx("f2_tx1", 8'hFF);
        expect_tx("f2_tx0", 8'hF5);
        check("f2_a",   32'(a),       32'h000F);
        check("f2_b",   32'(b),       32'h000A);
        check("f2_fun", 32'(alu_fun), 32'h6);

        // Back-pressure for 5 cycles in TX1
        alu_const = 17'h12345;
        send_byte(8'hDD);
        send_byte(8'h03);
        repeat (2) @(negedge clk);
        expect_tx("f3_tx2", 8'h01);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("f3_stall_valid", 32'(tx_valid), 32'h1);
            check("f3_stall_data",  32'(tx_data),  32'h23);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        expect_tx("f3_tx1", 8'h23);
        expect_tx("f3_tx0", 8'h45);
        check("f3_end_txv", 32'(tx_valid), 32'h0);

        // Stray byte in IDLE, then a byte during TX2
        alu_mode = 1'b0;
        send_byte(8'h55);
        check("f4_stray_busy", 32'(busy),     32'h0);
        check("f4_stray_a",    32'(a),        32'h000F);
        check("f4_stray_fun",  32'(alu_fun),  32'h3);
        check("f4_stray_txv",  32'(tx_valid), 32'h0);
        send_byte(8'hDD);
        send_byte(8'h09);
        repeat (2) @(negedge clk);
        tx_ready = 1'b0;
        send_byte(8'hCC);
        check("f4_drop",     32'(rx_drop),  32'h1);
        check("f4_hold_txv", 32'(tx_valid), 32'h1);
        check("f4_hold_txd", 32'(tx_data),  32'h00);
        check("f4_hold_a",   32'(a),        32'h000F);
        tx_ready = 1'b1;
        expect_tx("f4_tx2", 8'h00);
        expect_tx("f4_tx1", 8'h00);
        expect_tx("f4_tx0", 8'h19);
        check("f4_end_busy", 32'(busy),    32'h0);
        check("f4_drop_sticky", 32'(rx_drop), 32'h1);
        check("f4_fun",      32'(alu_fun), 32'h9);

        // Reset in the middle of a frame, then a clean frame
        send_byte(8'hCC);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("f5_part_a", 32'(a), 32'h1122);
        check("f5_part_b", 32'(b), 32'h330A);
        rst_n = 1'b0;
        #1;
        check("f5_rst_a",    32'(a),        32'h0);
        check("f5_rst_b",    32'(b),        32'h0);
        check("f5_rst_fun",  32'(alu_fun),  32'h0);
        check("f5_rst_busy", 32'(busy),     32'h0);
        check("f5_rst_drop", 32'(rx_drop),  32'h0);
        check("f5_rst_txd",  32'(tx_data),  32'h0);
        check("f5_rst_txv",  32'(tx_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("f5_idle_busy", 32'(busy), 32'h0);
        send_byte(8'hCC);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        send_byte(8'h56);
        send_byte(8'h00);
        check("f5_exec_en", 32'(alu_en), 32'h1);
        repeat (2) @(negedge clk);
        expect_tx("f5_tx2", 8'h00);
        expect_tx("f5_tx1", 8'h12);
        expect_tx("f5_tx0", 8'h8A);
        check("f5_a", 32'(a), 32'h1234);
        check("f5_b", 32'(b), 32'h0056);

`ifdef ALU_CMD_TIMEOUT_EN
        // Stalled frame times out after 256 idle cycles
        send_byte(8'hCC);
        repeat (255) @(negedge clk);
        check("f6_before_tmo_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("f6_after_tmo_busy", 32'(busy), 32'h0);
        repeat (44) @(negedge clk);
        check("f6_tmo_a", 32'(a), 32'h1234);
        send_byte(8'hDD);
        send_byte(8'h00);
        check("f6_exec_en", 32'(alu_en), 32'h1);
        repeat (2) @(negedge clk);
        expect_tx("f6_tx2", 8'h00);
        expect_tx("f6_tx1", 8'h12);
        expect_tx("f6_tx0", 8'h8A);
        check("f6_b", 32'(b), 32'h0056);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port rx_data, input, 8 bits: received command/operand byte.
REQ-004 SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-005 SHALL have port a, output, 16 bits: ALU operand A, registered.
REQ-006 SHALL have port b, output, 16 bits: ALU operand B, registered.
REQ-007 SHALL have port alu_fun, output, 4 bits: ALU function select, registered.
REQ-008 SHALL have port alu_en, output, 1 bit: one-cycle execute strobe, usable as ALU clock-gate enable.
REQ-009 SHALL have port alu_out, input, 17 bits: registered ALU result, valid one cycle after alu_en.
REQ-010 SHALL have port tx_data, output, 8 bits: result byte.
REQ-011 SHALL have port tx_valid, output, 1 bit: tx_data valid.
REQ-012 SHALL have port tx_ready, input, 1 bit: consumer accepts the byte when tx_valid and tx_ready are both high.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port rx_drop, output, 1 bit: sticky flag for rx_valid seen in EXEC/WAIT/TX states.

Function
REQ-015 SHALL use FSM states IDLE, GET_AH, GET_AL, GET_BH, GET_BL, GET_FUN, EXEC, WAIT, TX2, TX1, TX0.
REQ-016 SHALL, in IDLE on rx_valid with rx_data 0xCC, go to GET_AH; with 0xDD, go to GET_FUN; with any other byte, stay in IDLE with no output change.
REQ-017 SHALL, on each rx_valid, load a[15:8] in GET_AH, a[7:0] in GET_AL, b[15:8] in GET_BH and b[7:0] in GET_BL, then advance one state per byte.
REQ-018 SHALL, in GET_FUN on rx_valid, load alu_fun from rx_data[3:0], ignore rx_data[7:4], and go to EXEC.
REQ-019 SHALL let a 0xDD frame reuse the previously held a and b.
REQ-020 SHALL drive alu_en high only during the single EXEC cycle, then go to WAIT.
REQ-021 SHALL, in WAIT, capture {7'b0, alu_out} into a 24-bit result register and go to TX2.
REQ-022 SHALL present result bits [23:16], [15:8] and [7:0] in TX2, TX1 and TX0 with tx_valid high.
REQ-023 SHALL advance out of each TX state only on tx_valid and tx_ready, with TX0 returning to IDLE.
REQ-024 SHALL hold tx_data stable while tx_valid is high and tx_ready is low.
REQ-025 SHALL ensure latency from the GET_FUN byte edge to first tx_valid is exactly 2 cycles.
REQ-026 SHALL keep a, b and alu_fun unchanged outside their load states to avoid toggling.
REQ-027 SHALL, when rx_valid occurs in EXEC/WAIT/TX states, discard the byte and set rx_drop; rx_drop clears only on reset.
REQ-028 SHALL drive tx_valid low in all non-TX states.

Reset
REQ-029 SHALL, on rst_n low, asynchronously set state IDLE and clear a, b, alu_fun, the result register, tx_data, tx_valid, alu_en, busy and rx_drop to 0.
REQ-030 SHALL, on reset mid-frame or mid-transmit, abandon the frame; the first cycle after rst_n rises is IDLE.

Configuration
REQ-031 SHALL, with macro ALU_CMD_TIMEOUT_EN defined, run an 8-bit idle counter in GET_AH..GET_FUN that clears on rx_valid and forces IDLE without altering a/b/alu_fun after reaching 255; without the macro, SHALL wait for bytes indefinitely and contain no counter logic.

Verification
REQ-032 SHALL cover frame: bytes CC,00,0F,00,0A,00 with alu_out model = a+b -> alu_en one cycle, a=15, b=10, tx bytes 00,00,19.
REQ-033 SHALL cover frame: DD,06 after REQ-032 with model returning 0x1FFF5 -> a/b unchanged, alu_fun=6, tx bytes 01,FF,F5.
REQ-034 SHALL cover frame: tx_ready held low 5 cycles in TX1 -> tx_data stable at middle byte, no skipped or duplicate byte.
REQ-035 SHALL cover frame: byte 0x55 in IDLE then rx_valid during TX2 -> state stays IDLE for 0x55, then rx_drop=1 with output bytes unchanged.
REQ-036 SHALL cover frame: rst_n low after GET_BH -> all outputs 0, state IDLE; the next full CC frame completes correctly.
REQ-037 SHALL cover frame (ALU_CMD_TIMEOUT_EN defined): CC then 300 idle cycles -> IDLE after 256 cycles; a following DD,00 executes.
